// File: rtl/bitblade_pkg.sv
// Shared types and constants for the BitBlade accumulation sequencer.
// Precision codes select 1, 2 or 4 two-bit slices per operand.
package bitblade_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [1:0] P2B  = 2'd0;
    localparam logic [1:0] P4B  = 2'd1;
    localparam logic [1:0] P8B  = 2'd2;
    localparam logic [1:0] PRSV = 2'd3;

    localparam int PIPE_LAT_DEF = 2;

    // Index of the last 2-bit slice for a precision code.
    function automatic logic [1:0] slice_max(input logic [1:0] prec);
        logic [1:0] res;
        case (prec)
            P2B:     res = 2'd0;
            P4B:     res = 2'd1;
            P8B:     res = 2'd3;
            default: res = 2'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bitblade_acc_seq_if.sv
// Configuration, operand, PE-control, result and status signals of the sequencer.
// The slave modport is the sequencer side; master is the surrounding system.
interface bitblade_acc_seq_if #(
    parameter int TILE_W = 8
);
    logic              cfg_start;
    logic              cfg_abort;
    logic [1:0]        cfg_prec_i;
    logic [1:0]        cfg_prec_w;
    logic              cfg_sign_i;
    logic              cfg_sign_w;
    logic [TILE_W-1:0] cfg_tiles;
    logic              op_valid;
    logic              op_ready;
    logic              pe_en;
    logic              pe_flush;
    logic              pe_sign_i;
    logic              pe_sign_w;
    logic [3:0]        pe_shift;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              cfg_err;

    modport slave (
        input  cfg_start, cfg_abort, cfg_prec_i, cfg_prec_w, cfg_sign_i, cfg_sign_w,
        input  cfg_tiles, op_valid, out_ready,
        output op_ready, pe_en, pe_flush, pe_sign_i, pe_sign_w, pe_shift,
        output out_valid, busy, done, cfg_err
    );

    modport master (
        output cfg_start, cfg_abort, cfg_prec_i, cfg_prec_w, cfg_sign_i, cfg_sign_w,
        output cfg_tiles, op_valid, out_ready,
        input  op_ready, pe_en, pe_flush, pe_sign_i, pe_sign_w, pe_shift,
        input  out_valid, busy, done, cfg_err
    );
endinterface

// File: rtl/bitblade_slice_cnt.sv
// Nested pass counter: input slice innermost, then weight slice, then tile.
// Holds without step, wraps to zero after the last pass.
module bitblade_slice_cnt #(
    parameter int TILE_W = 8
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              clr,
    input  logic              step,
    input  logic [1:0]        si_max,
    input  logic [1:0]        sw_max,
    input  logic [TILE_W-1:0] t_max,
    output logic [1:0]        si,
    output logic [1:0]        sw,
    output logic              first,
    output logic              last
);
    logic [1:0]        si_r;
    logic [1:0]        sw_r;
    logic [TILE_W-1:0] t_r;
    logic              si_last_s;
    logic              sw_last_s;
    logic              t_last_s;

    // Wrap detection for each counter level.
    always_comb begin
        si_last_s = (si_r == si_max);
        sw_last_s = (sw_r == sw_max);
        t_last_s  = (t_r == t_max);
        last      = si_last_s && sw_last_s && t_last_s;
        first     = (si_r == 2'd0) && (sw_r == 2'd0) && (t_r == {TILE_W{1'b0}});
    end

    // Counter registers: carry ripples si -> sw -> t on each step.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            si_r <= 2'd0;
            sw_r <= 2'd0;
            t_r  <= {TILE_W{1'b0}};
        end else if (clr) begin
            si_r <= 2'd0;
            sw_r <= 2'd0;
            t_r  <= {TILE_W{1'b0}};
        end else if (step) begin
            if (!si_last_s) begin
                si_r <= si_r + 2'd1;
            end else begin
                si_r <= 2'd0;
                if (!sw_last_s) begin
                    sw_r <= sw_r + 2'd1;
                end else begin
                    sw_r <= 2'd0;
                    t_r  <= t_last_s ? {TILE_W{1'b0}} : t_r + {{(TILE_W-1){1'b0}}, 1'b1};
                end
            end
        end else begin
            si_r <= si_r;
            sw_r <= sw_r;
            t_r  <= t_r;
        end
    end

    assign si = si_r;
    assign sw = sw_r;
endmodule

// File: rtl/bitblade_acc_seq.sv
// Sequences bit-sliced MAC passes into the PE array, waits out the pipeline,
// then hands the finished psum to writeback.
module bitblade_acc_seq
    import bitblade_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int TILE_W   = 8
) (
    input logic CLK,
    input logic RSTN,
    bitblade_acc_seq_if.slave bus
);
    localparam logic [2:0] DRAIN_LAST = 3'(PIPE_LAT - 1);

    state_t            state_r, state_nx_s;
    logic [1:0]        prec_i_r, prec_w_r;
    logic              sign_i_r, sign_w_r;
    logic [TILE_W-1:0] tiles_r;
    logic [2:0]        drain_r;
    logic              cfg_ok_s, issue_s, start_s, drain_last_s;
    logic [1:0]        si_s, sw_s, si_max_s, sw_max_s;
    logic [TILE_W-1:0] t_max_s;
    logic              first_s, last_s;
    logic [3:0]        shift_s;
    logic              pe_en_r, pe_flush_r, pe_sign_i_r, pe_sign_w_r;
    logic [3:0]        pe_shift_r;
    logic              op_ready_r, out_valid_r, busy_r, done_r, cfg_err_r;

    bitblade_slice_cnt #(.TILE_W(TILE_W)) u_cnt (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .clr    (state_r != RUN),
        .step   (issue_s),
        .si_max (si_max_s),
        .sw_max (sw_max_s),
        .t_max  (t_max_s),
        .si     (si_s),
        .sw     (sw_s),
        .first  (first_s),
        .last   (last_s)
    );

    // Next-state decode; abort outranks both handshakes.
    always_comb begin
        si_max_s     = slice_max(prec_i_r);
        sw_max_s     = slice_max(prec_w_r);
        t_max_s      = tiles_r - {{(TILE_W-1){1'b0}}, 1'b1};
        cfg_ok_s     = (bus.cfg_prec_i != PRSV) && (bus.cfg_prec_w != PRSV) &&
                       (bus.cfg_tiles != {TILE_W{1'b0}});
        issue_s      = (state_r == RUN) && bus.op_valid && !bus.cfg_abort;
        start_s      = (state_r == IDLE) && bus.cfg_start && cfg_ok_s;
        drain_last_s = (drain_r == DRAIN_LAST);
        shift_s      = {1'b0, si_s, 1'b0} + {1'b0, sw_s, 1'b0};
        state_nx_s   = state_r;
        case (state_r)
            IDLE:    state_nx_s = start_s ? RUN : IDLE;
            RUN: begin
                if (bus.cfg_abort)          state_nx_s = IDLE;
                else if (issue_s && last_s) state_nx_s = DRAIN;
                else                        state_nx_s = RUN;
            end
            DRAIN: begin
                if (bus.cfg_abort)    state_nx_s = IDLE;
                else if (drain_last_s) state_nx_s = OUT;
                else                  state_nx_s = DRAIN;
            end
            OUT: begin
                if (bus.cfg_abort)      state_nx_s = IDLE;
                else if (bus.out_ready) state_nx_s = IDLE;
                else                    state_nx_s = OUT;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register and drain cycle counter.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r <= IDLE;
            drain_r <= 3'd0;
        end else begin
            state_r <= state_nx_s;
            drain_r <= (state_r == DRAIN) ? drain_r + 3'd1 : 3'd0;
        end
    end

    // Job configuration captured only on an accepted start.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            prec_i_r <= 2'd0;
            prec_w_r <= 2'd0;
            sign_i_r <= 1'b0;
            sign_w_r <= 1'b0;
            tiles_r  <= {TILE_W{1'b0}};
        end else if (start_s) begin
            prec_i_r <= bus.cfg_prec_i;
            prec_w_r <= bus.cfg_prec_w;
            sign_i_r <= bus.cfg_sign_i;
            sign_w_r <= bus.cfg_sign_w;
            tiles_r  <= bus.cfg_tiles;
        end else begin
            prec_i_r <= prec_i_r;
            prec_w_r <= prec_w_r;
            sign_i_r <= sign_i_r;
            sign_w_r <= sign_w_r;
            tiles_r  <= tiles_r;
        end
    end

    // Registered outputs: PE controls describe the pass issued last cycle.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pe_en_r     <= 1'b0;
            pe_flush_r  <= 1'b0;
            pe_sign_i_r <= 1'b0;
            pe_sign_w_r <= 1'b0;
            pe_shift_r  <= 4'd0;
            op_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            pe_en_r     <= issue_s;
            pe_flush_r  <= issue_s && first_s;
            pe_sign_i_r <= issue_s && sign_i_r && (si_s == si_max_s);
            pe_sign_w_r <= issue_s && sign_w_r && (sw_s == sw_max_s);
            pe_shift_r  <= issue_s ? shift_s : 4'd0;
            op_ready_r  <= (state_nx_s == RUN);
            out_valid_r <= (state_nx_s == OUT);
            busy_r      <= (state_nx_s != IDLE);
            done_r      <= (state_r == OUT) && bus.out_ready && !bus.cfg_abort;
            cfg_err_r   <= (state_r == IDLE) && bus.cfg_start && !cfg_ok_s;
        end
    end

    assign bus.op_ready  = op_ready_r;
    assign bus.pe_en     = pe_en_r;
    assign bus.pe_flush  = pe_flush_r;
    assign bus.pe_sign_i = pe_sign_i_r;
    assign bus.pe_sign_w = pe_sign_w_r;
    assign bus.pe_shift  = pe_shift_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.cfg_err   = cfg_err_r;
endmodule
